// File: rtl/axi4l_pkg.sv
// ============================================================================
// Module : axi4l_pkg
// Brief  : Shared AXI4-Lite response codes and read-channel FSM state type.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi4l_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } rd_state_t;

endpackage

`default_nettype wire

// File: rtl/s_axi4l_rd_timer.sv
// ============================================================================
// Module : s_axi4l_rd_timer
// Brief  : Wait-cycle counter; expired flags the last allowed enabled cycle.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module s_axi4l_rd_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int             CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    // Count 0 is the first enabled cycle, so TIMEOUT-1 marks the TIMEOUT-th one.
    assign o_expired = i_enable && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/s_axi4l_rd_channel.sv
// ============================================================================
// Module : s_axi4l_rd_channel
// Brief  : AXI4-Lite slave read channel bridging to a register-file read port.
//          Define S_AXI4L_RD_ADDR_CHECK_EN to reject misaligned/out-of-range reads.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module s_axi4l_rd_channel
    import axi4l_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16,
    parameter int TIMEOUT    = 15
) (
    input  logic                  i_axi_clock,
    input  logic                  i_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] i_axi_araddr,
    input  logic [2:0]            i_axi_arprot,
    input  logic                  i_axi_araddr_valid,
    output logic                  o_axi_araddr_ready,
    output logic [DATA_WIDTH-1:0] o_axi_rdata,
    output logic [1:0]            o_axi_rresp,
    output logic                  o_axi_rvalid,
    input  logic                  i_axi_rready,
    output logic [ADDR_WIDTH-1:0] o_raddr,
    output logic                  o_rreq,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  i_rvalid
);

    rd_state_t             r_state, w_state_next;
    logic                  r_arready, w_arready;
    logic                  r_rvalid, w_rvalid;
    logic [1:0]            r_rresp, w_rresp;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata;
    logic                  r_rreq, w_rreq;
    logic [ADDR_WIDTH-1:0] r_raddr, w_raddr;
    logic                  w_ar_hs, w_r_hs, w_addr_bad, w_expired;
    logic                  w_unused;

    // Protection bits carry no meaning for this register file.
    assign w_unused = &{1'b0, i_axi_arprot};

    assign w_ar_hs = i_axi_araddr_valid && r_arready;
    assign w_r_hs  = r_rvalid && i_axi_rready;

`ifdef S_AXI4L_RD_ADDR_CHECK_EN
    assign w_addr_bad = (i_axi_araddr[1:0] != 2'b00) ||
                        ((i_axi_araddr >> 2) >= ADDR_WIDTH'(NUM_REGS));
`else
    assign w_addr_bad = 1'b0;
`endif

    s_axi4l_rd_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (i_axi_clock),
        .rst_n     (i_axi_aresetn),
        .i_clear   (r_state == RD_REQ),
        .i_enable  (r_state == RD_WAIT),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_axi_clock or negedge i_axi_aresetn) begin
        if (!i_axi_aresetn) begin
            r_state   <= IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= 2'b00;
            r_rdata   <= '0;
            r_rreq    <= 1'b0;
            r_raddr   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_arready <= w_arready;
            r_rvalid  <= w_rvalid;
            r_rresp   <= w_rresp;
            r_rdata   <= w_rdata;
            r_rreq    <= w_rreq;
            r_raddr   <= w_raddr;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_ar_hs) w_state_next = w_addr_bad ? RESP : RD_REQ;
            RD_REQ:  w_state_next = RD_WAIT;
            RD_WAIT: if (i_rvalid || w_expired) w_state_next = RESP;
            RESP:    if (w_r_hs) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs; rdata/rresp hold unless reloaded.
    always_comb begin
        w_arready = 1'b0;
        w_rreq    = 1'b0;
        w_rvalid  = r_rvalid;
        w_rresp   = r_rresp;
        w_rdata   = r_rdata;
        w_raddr   = r_raddr;
        unique case (r_state)
            IDLE: begin
                w_arready = 1'b1;
                if (w_ar_hs) begin
                    w_arready = 1'b0;
                    if (w_addr_bad) begin
                        w_rvalid = 1'b1;
                        w_rresp  = RESP_SLVERR;
                        w_rdata  = '0;
                    end else begin
                        w_rreq  = 1'b1;
                        w_raddr = i_axi_araddr;
                    end
                end
            end
            RD_REQ: ;
            RD_WAIT: begin
                if (i_rvalid) begin
                    w_rvalid = 1'b1;
                    w_rresp  = RESP_OKAY;
                    w_rdata  = i_rdata;
                end else if (w_expired) begin
                    w_rvalid = 1'b1;
                    w_rresp  = RESP_SLVERR;
                    w_rdata  = '0;
                end
            end
            RESP: begin
                if (w_r_hs) begin
                    w_rvalid  = 1'b0;
                    w_arready = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign o_axi_araddr_ready = r_arready;
    assign o_axi_rvalid       = r_rvalid;
    assign o_axi_rresp        = r_rresp;
    assign o_axi_rdata        = r_rdata;
    assign o_rreq             = r_rreq;
    assign o_raddr            = r_raddr;

endmodule

`default_nettype wire

// File: tb/tb_s_axi4l_rd_channel.sv
// ============================================================================
// Module : tb_s_axi4l_rd_channel
// Brief  : Randomized self-checking bench with a transaction-timing model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_s_axi4l_rd_channel;

    localparam int NUM_REGS = 16;
    localparam int TIMEOUT  = 15;
    localparam logic [1:0] c_okay   = 2'b00;
    localparam logic [1:0] c_slverr = 2'b10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] raddr;
    logic        rreq;
    logic [31:0] rf_rdata;
    logic        rf_rvalid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    s_axi4l_rd_channel #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (NUM_REGS),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .i_axi_clock        (clk),
        .i_axi_aresetn      (rst_n),
        .i_axi_araddr       (araddr),
        .i_axi_arprot       (arprot),
        .i_axi_araddr_valid (arvalid),
        .o_axi_araddr_ready (arready),
        .o_axi_rdata        (rdata),
        .o_axi_rresp        (rresp),
        .o_axi_rvalid       (rvalid),
        .i_axi_rready       (rready),
        .o_raddr            (raddr),
        .o_rreq             (rreq),
        .i_rdata            (rf_rdata),
        .i_rvalid           (rf_rvalid)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_arready"}, {31'd0, arready}, 32'd0);
        check_val({tag, "_rvalid"},  {31'd0, rvalid},  32'd0);
        check_val({tag, "_rresp"},   {30'd0, rresp},   32'd0);
        check_val({tag, "_rdata"},   rdata,            32'd0);
        check_val({tag, "_rreq"},    {31'd0, rreq},    32'd0);
        check_val({tag, "_raddr"},   raddr,            32'd0);
    endtask

    // One read: d = cycles from the rreq cycle to the register-file return
    // (0 = never), m = cycles rready stays low once rvalid appears (0 = held high).
    // Relative cycle c counts clock periods after the AR handshake edge.
    task automatic do_read(input logic [31:0] addr, input int d,
                           input logic [31:0] data, input int m);
        bit bad;
        bit ok;
        int r;
        bad = 1'b0;
`ifdef S_AXI4L_RD_ADDR_CHECK_EN
        bad = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'(NUM_REGS));
`endif
        ok = !bad && (d >= 1) && (d <= TIMEOUT);
        if (bad)     r = 1;
        else if (ok) r = 2 + d;
        else         r = 2 + TIMEOUT;

        check_val("arready_before", {31'd0, arready}, 32'd1);
        araddr    = addr;
        arprot    = 3'($urandom);
        arvalid   = 1'b1;
        rf_rvalid = 1'($urandom);
        rf_rdata  = $urandom;
        rready    = (m == 0);
        for (int c = 1; c <= r + m + 1; c++) begin
            @(negedge clk);
            check_val("rreq", {31'd0, rreq}, {31'd0, (c == 1) && !bad});
            if (c == 1 && !bad) check_val("raddr", raddr, addr);
            check_val("rvalid",  {31'd0, rvalid},  {31'd0, (c >= r) && (c <= r + m)});
            check_val("arready", {31'd0, arready}, {31'd0, c > r + m});
            if (c >= r && c <= r + m) begin
                check_val("rdata", rdata, ok ? data : 32'd0);
                check_val("rresp", {30'd0, rresp}, {30'd0, ok ? c_okay : c_slverr});
            end
            if (c <= r + m) begin
                // Stray AR traffic and register-file strobes outside the wait window.
                arvalid   = 1'($urandom);
                araddr    = $urandom;
                rf_rvalid = (c == 1 + d) || ((c == 1 || c >= r) && 1'($urandom));
                rf_rdata  = (c == 1 + d) ? data : $urandom;
                rready    = (m == 0) || (c >= r + m);
            end
        end
        arvalid   = 1'b0;
        rf_rvalid = 1'b0;
    endtask

    task automatic do_reset_mid(input logic [31:0] addr);
        check_val("arready_pre_rst", {31'd0, arready}, 32'd1);
        araddr    = addr;
        arvalid   = 1'b1;
        rready    = 1'b0;
        rf_rvalid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            arvalid = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_async");
        repeat (2) @(negedge clk);
        check_all_zero("rst_held");
        rst_n     = 1'b1;
        rf_rvalid = 1'b1;
        rf_rdata  = 32'hCAFE_F00D;
        rready    = 1'b1;
        @(negedge clk);
        check_val("arready_after_rst", {31'd0, arready}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_val("aborted_rvalid", {31'd0, rvalid}, 32'd0);
            check_val("aborted_rreq",   {31'd0, rreq},   32'd0);
        end
        rf_rvalid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          dly;
        int          hold;

        rst_n     = 1'b0;
        araddr    = '0;
        arprot    = '0;
        arvalid   = 1'b0;
        rready    = 1'b0;
        rf_rdata  = '0;
        rf_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_val("arready_first_edge", {31'd0, arready}, 32'd1);

        do_read(32'h8, 1, 32'hDEAD_BEEF, 0);
        do_read(32'h4, 2, 32'h1357_9BDF, 5);
        do_read(32'h0, 0, 32'h0BAD_0BAD, 0);
        do_read(32'h3C, TIMEOUT, 32'hA5A5_5A5A, 1);
        do_read(32'h10, TIMEOUT + 1, 32'h7777_7777, 0);
        do_read(32'h42, 3, 32'h4242_4242, 0);
        do_read(32'h40, 3, 32'h4040_4040, 2);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       a = $urandom;
                1:       a = {26'd0, 4'($urandom), 2'($urandom)};
                default: a = {26'd0, 4'($urandom), 2'b00};
            endcase
            dly  = $urandom_range(0, TIMEOUT + 3);
            hold = $urandom_range(0, 1) ? 0 : $urandom_range(1, 4);
            do_read(a, dly, $urandom, hold);
        end

        do_reset_mid(32'hC);
        do_read(32'h14, 4, 32'h0F0F_F0F0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/s_axi4l_rd_channel.md
S_AXI4L_RD_CHANNEL -- requirements
Module: s_axi4l_rd_channel

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI read address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, read data width in bits.
REQ-003 SHALL have parameter NUM_REGS, default 16, number of 32-bit registers in the register file.
REQ-004 SHALL have parameter TIMEOUT, default 15, maximum number of RD_WAIT cycles before an error response.
REQ-005 SHALL have i_axi_clock, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have i_axi_aresetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have i_axi_araddr, input, ADDR_WIDTH, read byte address.
REQ-008 SHALL have i_axi_arprot, input, 3, protection bits, captured and ignored.
REQ-009 SHALL have i_axi_araddr_valid, input, 1, and o_axi_araddr_ready, output, 1, the AR handshake pair.
REQ-010 SHALL have o_axi_rdata, output, DATA_WIDTH, and o_axi_rresp, output, 2, the read data and response.
REQ-011 SHALL have o_axi_rvalid, output, 1, and i_axi_rready, input, 1, the R handshake pair.
REQ-012 SHALL have o_raddr, output, ADDR_WIDTH, the register-file read byte address.
REQ-013 SHALL have o_rreq, output, 1, a one-cycle register-file read strobe.
REQ-014 SHALL have i_rdata, input, DATA_WIDTH, and i_rvalid, input, 1, the register-file read return.

Function
REQ-015 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT and RESP; all outputs SHALL be registered.
REQ-016 IDLE: o_axi_araddr_ready SHALL be 1; when araddr_valid and ready are both high, the block SHALL capture the address, drop ready the next cycle and go to RD_REQ.
REQ-017 RD_REQ: o_rreq SHALL be 1 for exactly one cycle with o_raddr equal to the captured address; the FSM SHALL then go to RD_WAIT and clear the timeout counter.
REQ-018 RD_WAIT: on i_rvalid, the block SHALL load o_axi_rdata from i_rdata, set rresp to OKAY (2'b00), set rvalid to 1 and go to RESP.
REQ-019 RD_WAIT timeout: after TIMEOUT cycles without i_rvalid, the block SHALL set rdata to 0, rresp to SLVERR (2'b10), rvalid to 1 and go to RESP.
REQ-020 If i_rvalid and the timeout occur in the same cycle, i_rvalid SHALL win.
REQ-021 i_rvalid SHALL be ignored in any state other than RD_WAIT.
REQ-022 RESP: rdata, rresp and rvalid SHALL stay stable until i_axi_rready; on the handshake, rvalid SHALL be 0 and araddr_ready SHALL be 1 on the next cycle (IDLE).
REQ-023 Minimum latency, with the AR handshake on edge N: o_rreq is high in cycle N+1, the earliest i_rvalid is in cycle N+2, and rvalid is high from N+3.
REQ-024 The block SHALL handle one outstanding transaction only; araddr_ready SHALL be 0 in every state except IDLE.
REQ-025 An i_axi_rready held high before rvalid SHALL complete the handshake in the first cycle rvalid is high.

Reset
REQ-026 While i_axi_aresetn is 0, the block SHALL force state to IDLE, araddr_ready to 0, rvalid to 0, rresp to 0, rdata to 0, o_rreq to 0, o_raddr to 0 and the counter to 0.
REQ-027 araddr_ready SHALL rise on the first clock edge after reset release.
REQ-028 A reset mid-transaction SHALL abort it; no rvalid or rreq for the aborted read SHALL appear afterwards.

Configuration
REQ-029 With macro S_AXI4L_RD_ADDR_CHECK_EN defined, the block SHALL, on an AR handshake with addr[1:0]!=0 or addr>>2 >= NUM_REGS, skip RD_REQ/RD_WAIT, assert no o_rreq, and set rvalid the next cycle with SLVERR and rdata 0.
REQ-030 With S_AXI4L_RD_ADDR_CHECK_EN undefined, the block SHALL forward every address unchanged to the register file, and only a timeout SHALL produce SLVERR.

Structure
REQ-031 The shared package axi4l_pkg SHALL hold the response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 and the enum rd_state_t.
REQ-032 The timeout counter SHALL be the sub-module s_axi4l_rd_timer, with clear, enable and expired ports.

Verification
REQ-033 Read addr 0x8, i_rvalid one cycle after rreq with data 0xDEADBEEF, rready held high: SHALL give rdata 0xDEADBEEF, OKAY, with rvalid at N+3.
REQ-034 Read addr 0x4 with rready held low for 5 cycles: rvalid, rdata and rresp SHALL stay stable for all 5 cycles, and araddr_ready SHALL be 0 throughout.
REQ-035 Read addr 0x0 with i_rvalid never asserted: SHALL give SLVERR with rdata 0 after 15 RD_WAIT cycles, and no further rreq.
REQ-036 With S_AXI4L_RD_ADDR_CHECK_EN defined, reads of 0x42 and 0x40 (NUM_REGS=16): SHALL give SLVERR for both, with o_rreq never high.
REQ-037 Reset asserted during RD_WAIT, then i_rvalid driven after release: all outputs SHALL be 0 during reset, araddr_ready SHALL be 1 after release, and rvalid SHALL stay 0.
